// File: rtl/stream_demux.sv
// stream_demux: routes one upstream valid/ready stream to one of OUTPUTS
// single-entry output slots chosen by in_select.
// Ports: clk, reset (async, active-high); upstream in_valid/in_ready/in_data/in_select;
// downstream out_valid/out_ready/out_data (port k at bits [k*WIDTH +: WIDTH]);
// drop pulses for a discarded out-of-range word; occupancy counts full slots.
// Latency: one cycle into a slot. Backpressure: in_ready follows the selected
// slot only (free, or draining this cycle); an out-of-range select is always accepted.
module stream_demux #(
  parameter int WIDTH   = 8,
  parameter int OUTPUTS = 8,
  parameter int WSEL    = $clog2(OUTPUTS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic [WSEL-1:0]              in_select,
  output logic [OUTPUTS-1:0]           out_valid,
  input  logic [OUTPUTS-1:0]           out_ready,
  output logic [WIDTH*OUTPUTS-1:0]     out_data,
  output logic                         drop,
  output logic [$clog2(OUTPUTS+1)-1:0] occupancy
);

  localparam int OCCW = $clog2(OUTPUTS + 1);

  logic [OUTPUTS-1:0]       valid_q, valid_d;
  logic [WIDTH*OUTPUTS-1:0] data_q, data_d;
  logic                     drop_q, drop_d;
  logic [OCCW-1:0]          occ_q, occ_d;
  logic                     port_busy;
  logic                     in_range;
  logic                     accept;

  // Decode the select against every port index so that an out-of-range
  // select simply matches nothing: it is never busy and never writes.
  always_comb begin
    port_busy = 1'b0;
    in_range  = 1'b0;
    for (int k = 0; k < OUTPUTS; k++) begin
      if (in_select == WSEL'(k)) begin
        in_range  = 1'b1;
        port_busy = valid_q[k] && !out_ready[k];
      end
    end
  end

  assign in_ready = !port_busy;
  assign accept   = in_valid && in_ready;

  // Drain first, then fill: a slot drained and refilled on the same edge
  // stays valid and takes the new word.
  always_comb begin
    valid_d = valid_q & ~(valid_q & out_ready);
    data_d  = data_q;
    for (int k = 0; k < OUTPUTS; k++) begin
      if (accept && in_select == WSEL'(k)) begin
        valid_d[k]                  = 1'b1;
        data_d[k*WIDTH +: WIDTH]    = in_data;
      end
    end
    drop_d = accept && !in_range;
    occ_d  = '0;
    for (int k = 0; k < OUTPUTS; k++) begin
      occ_d = occ_d + OCCW'(valid_d[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= 1'b0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      occ_q   <= occ_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop      = drop_q;
  assign occupancy = occ_q;

endmodule
